// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path and its ALU decoder.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    RS_ALUOUT    = 2'b00,
    RS_DATA      = 2'b01,
    RS_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

endpackage

// File: rtl/multicycle_ctrl_instr_dec.sv
// Combinational opcode -> immediate-format decode.
module instr_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  imm_src_t w_imm;

  always_comb begin
    w_imm = IMM_I;
    case (op)
      OP_LW, OP_I: w_imm = IMM_I;
      OP_SW:       w_imm = IMM_S;
      OP_BEQ:      w_imm = IMM_B;
      OP_JAL:      w_imm = IMM_J;
      default:     w_imm = IMM_I;
    endcase
  end

  assign imm_src = w_imm;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences the shared datapath for lw/sw/R/I/beq/jal,
// stalls on the memory handshake and traps (or skips) unimplemented opcodes.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       retire,
  output logic       illegal
);

  state_t      r_state;
  state_t      w_next;
  result_src_t w_res_src;
  alu_src_a_t  w_src_a;
  alu_src_b_t  w_src_b;
  alu_op_t     w_alu_op;
  logic        w_adr_src;
  logic        w_pc_update;
  logic        w_branch;
  logic        w_ir_write;
  logic        w_mem_write;
  logic        w_reg_write;
  logic        w_retire;
  logic        w_illegal;

  instr_dec u_instr_dec (
    .op      (op),
    .imm_src (imm_src)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_adr_src   = 1'b0;
    w_res_src   = RS_ALUOUT;
    w_src_a     = SRCA_PC;
    w_src_b     = SRCB_RD2;
    w_alu_op    = ALUOP_ADD;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_retire    = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_src_b     = SRCB_FOUR;
        w_res_src   = RS_ALURESULT;
        w_ir_write  = mem_ready;
        w_pc_update = mem_ready;
      end
      // Branch target is precomputed here so BEQ only needs the compare.
      S_DECODE: begin
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        w_src_a = SRCA_RD1;
        w_src_b = SRCB_IMM;
      end
      S_MEMREAD: w_adr_src = 1'b1;
      S_MEMWB: begin
        w_res_src   = RS_DATA;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = mem_ready;
      end
      S_EXECR: begin
        w_src_a  = SRCA_RD1;
        w_alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        w_src_a  = SRCA_RD1;
        w_src_b  = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BEQ: begin
        w_src_a  = SRCA_RD1;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
        w_retire = 1'b1;
      end
      S_JAL: begin
        w_src_a     = SRCA_OLDPC;
        w_src_b     = SRCB_FOUR;
        w_pc_update = 1'b1;
      end
      S_TRAP:  w_illegal = 1'b1;
      default: ;
    endcase
  end

  assign adr_src    = w_adr_src;
  assign result_src = w_res_src;
  assign alu_src_a  = w_src_a;
  assign alu_src_b  = w_src_b;
  assign alu_op     = w_alu_op;
  assign pc_write   = reset & (w_pc_update | (w_branch & zero));
  assign ir_write   = reset & w_ir_write;
  assign mem_write  = reset & w_mem_write;
  assign reg_write  = reset & w_reg_write;
  assign retire     = reset & w_retire;
  assign illegal    = reset & w_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: one instance per TRAP_ON_ILLEGAL setting, checked each cycle
// against an instruction-progress model, plus literal CPI/strobe-count expectations.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [6:0] op = 7'b0000011;

  logic       pcw[2], adr[2], mw[2], irw[2], rw[2], ret[2], ill[2];
  logic [1:0] rs[2], sa[2], sb[2], imm[2], aop[2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .reset(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pcw[1]), .adr_src(adr[1]), .mem_write(mw[1]), .ir_write(irw[1]),
    .result_src(rs[1]), .alu_src_a(sa[1]), .alu_src_b(sb[1]), .imm_src(imm[1]),
    .alu_op(aop[1]), .reg_write(rw[1]), .retire(ret[1]), .illegal(ill[1])
  );

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .reset(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pcw[0]), .adr_src(adr[0]), .mem_write(mw[0]), .ir_write(irw[0]),
    .result_src(rs[0]), .alu_src_a(sa[0]), .alu_src_b(sb[0]), .imm_src(imm[0]),
    .alu_op(aop[0]), .reg_write(rw[0]), .retire(ret[0]), .illegal(ill[0])
  );

  // Packed view: [16]pc_write [15]adr_src [14]mem_write [13]ir_write [12:11]result_src
  // [10:9]alu_src_a [8:7]alu_src_b [6:5]imm_src [4:3]alu_op [2]reg_write [1]retire [0]illegal
  function automatic logic [16:0] obs(input int p);
    return {pcw[p], adr[p], mw[p], irw[p], rs[p], sa[p], sb[p], imm[p], aop[p],
            rw[p], ret[p], ill[p]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
    end
  endtask

  // ---------------- model: progress through the current instruction ----------------
  // step 0 = fetch, 1 = decode, 2.. = opcode-specific cycles; stalls do not advance.
  int m_step[2];
  bit m_trap[2];

  function automatic int last_step(input logic [6:0] opc);
    case (opc)
      7'b0000011: return 4;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 3;
      7'b1100011: return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] opc);
    case (opc)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [16:0] model_out(input int step, input bit trap,
      input logic [6:0] opc, input logic rn, input logic mr, input logic z);
    logic pc_w, ad, m_w, ir_w, r_w, rt, il;
    logic [1:0] r_s, a, b, ao;
    {pc_w, ad, m_w, ir_w, r_w, rt, il} = '0;
    {r_s, a, b, ao} = '0;
    if (!rn) begin
      r_s = 2'b10; b = 2'b10;
    end else if (trap) begin
      il = 1'b1;
    end else if (step == 0) begin
      r_s = 2'b10; b = 2'b10; ir_w = mr; pc_w = mr;
    end else if (step == 1) begin
      a = 2'b01; b = 2'b01;
    end else begin
      case (opc)
        7'b0000011: case (step)
          2: begin a = 2'b10; b = 2'b01; end
          3: ad = 1'b1;
          default: begin r_s = 2'b01; r_w = 1'b1; rt = 1'b1; end
        endcase
        7'b0100011: if (step == 2) begin a = 2'b10; b = 2'b01; end
                    else begin ad = 1'b1; m_w = 1'b1; rt = mr; end
        7'b0110011: if (step == 2) begin a = 2'b10; ao = 2'b10; end
                    else begin r_w = 1'b1; rt = 1'b1; end
        7'b0010011: if (step == 2) begin a = 2'b10; b = 2'b01; ao = 2'b10; end
                    else begin r_w = 1'b1; rt = 1'b1; end
        7'b1100011: begin a = 2'b10; ao = 2'b01; pc_w = z; rt = 1'b1; end
        default:    if (step == 2) begin a = 2'b01; b = 2'b10; pc_w = 1'b1; end
                    else begin r_w = 1'b1; rt = 1'b1; end
      endcase
    end
    return {pc_w, ad, m_w, ir_w, r_s, a, b, imm_of(opc), ao, r_w, rt, il};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int p = 0; p < 2; p++) begin
      if (!rst_n) begin
        m_step[p] <= 0;
        m_trap[p] <= 1'b0;
      end else if (!m_trap[p]) begin
        if (m_step[p] == 0) begin
          if (mem_ready) m_step[p] <= 1;
        end else if (m_step[p] == 1) begin
          if (last_step(op) > 0) m_step[p] <= 2;
          else if (p == 1)       m_trap[p] <= 1'b1;
          else                   m_step[p] <= 0;
        end else if (m_step[p] == 3 && !mem_ready &&
                     (op == 7'b0000011 || op == 7'b0100011)) begin
          m_step[p] <= 3;
        end else if (m_step[p] >= last_step(op)) begin
          m_step[p] <= 0;
        end else begin
          m_step[p] <= m_step[p] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cycle_dut1", {15'd0, obs(1)},
          {15'd0, model_out(m_step[1], m_trap[1], op, rst_n, mem_ready, zero)});
    check("cycle_dut0", {15'd0, obs(0)},
          {15'd0, model_out(m_step[0], m_trap[0], op, rst_n, mem_ready, zero)});
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic mr, input logic z, output logic [16:0] s1,
                      output logic [16:0] s0);
    mem_ready = mr;
    zero = z;
    @(negedge clk);
    s1 = obs(1);
    s0 = obs(0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string nm, input logic [6:0] opc, input int stalls,
                           input logic z, input int cpi_req,
                           output int n_mw, output int n_rw, output int rw_cyc,
                           output int n_br, output int n_rs01, output int n_immj);
    logic [16:0] s1, s0;
    logic mr;
    int cyc, used;
    bit done, is_mem;
    cyc = 0; used = 0; done = 1'b0;
    n_mw = 0; n_rw = 0; rw_cyc = 0; n_br = 0; n_rs01 = 0; n_immj = 0;
    op = opc;
    is_mem = (opc == 7'b0000011) || (opc == 7'b0100011);
    while (!done && cyc < 40) begin
      mr = !(is_mem && (cyc - used) == 3 && used < stalls);
      if (!mr) used++;
      tick(mr, z, s1, s0);
      cyc++;
      if (s1[14]) n_mw++;
      if (s1[2]) begin n_rw++; rw_cyc = cyc; end
      if (s1[16] && !s1[13]) n_br++;
      if (s1[12:11] == 2'b01) n_rs01++;
      if (s1[6:5] == 2'b11) n_immj++;
      if (s1[1]) done = 1'b1;
    end
    check({nm, "_retired"}, {31'd0, done}, 32'd1);
    check({nm, "_cpi"}, cyc, cpi_req);
    $display("[TB] %s op=%b stalls=%0d zero=%0d cycles=%0d", nm, opc, stalls, z, cyc);
  endtask

  initial begin
    logic [16:0] s1, s0;
    int n_mw, n_rw, rw_cyc, n_br, n_rs01, n_immj, n_ill, n_str, n_ret0, n_ir0;

    // reset state: strobes low, fetch selects
    tick(1'b1, 1'b0, s1, s0);
    check("reset_strobes", {15'd0, s1 & 17'h1E007}, 32'd0);
    check("reset_selects", {22'd0, s1[12:7]}, {22'd0, 6'b10_00_10});
    rst_n = 1'b1;

    // reset mid-MEMREAD
    op = 7'b0000011;
    repeat (3) tick(1'b1, 1'b0, s1, s0);
    tick(1'b0, 1'b0, s1, s0);
    check("memread_adr_src", {31'd0, s1[15]}, 32'd1);
    rst_n = 1'b0;
    n_str = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, s1, s0);
      if (s1[14] || s1[2] || s1[13] || s1[16]) n_str++;
    end
    check("reset_mid_no_strobe", n_str, 0);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, s1, s0);
    check("release_ir_write", {31'd0, s1[13]}, 32'd1);
    repeat (3) tick(1'b1, 1'b0, s1, s0);
    tick(1'b1, 1'b0, s1, s0);
    check("release_lw_retire", {31'd0, s1[1]}, 32'd1);

    // fetch stall holds in FETCH without ir_write
    tick(1'b0, 1'b0, s1, s0);
    check("fetch_stall_ir_write", {31'd0, s1[13]}, 32'd0);

    run_instr("lw", 7'b0000011, 0, 1'b0, 5, n_mw, n_rw, rw_cyc, n_br, n_rs01, n_immj);
    check("lw_reg_write_count", n_rw, 1);
    check("lw_reg_write_cycle", rw_cyc, 5);
    check("lw_rs01_count", n_rs01, 1);
    run_instr("lw_stall", 7'b0000011, 1, 1'b0, 6, n_mw, n_rw, rw_cyc, n_br, n_rs01, n_immj);
    check("lw_stall_reg_write_cycle", rw_cyc, 6);

    run_instr("sw_stall", 7'b0100011, 2, 1'b0, 6, n_mw, n_rw, rw_cyc, n_br, n_rs01, n_immj);
    check("sw_mem_write_cycles", n_mw, 3);
    check("sw_reg_write_count", n_rw, 0);
    run_instr("sw", 7'b0100011, 0, 1'b0, 4, n_mw, n_rw, rw_cyc, n_br, n_rs01, n_immj);
    check("sw_mem_write_cycles_nostall", n_mw, 1);

    run_instr("rtype", 7'b0110011, 0, 1'b0, 4, n_mw, n_rw, rw_cyc, n_br, n_rs01, n_immj);
    check("rtype_reg_write_cycle", rw_cyc, 4);
    run_instr("itype", 7'b0010011, 0, 1'b0, 4, n_mw, n_rw, rw_cyc, n_br, n_rs01, n_immj);
    check("itype_reg_write_cycle", rw_cyc, 4);

    run_instr("beq_taken", 7'b1100011, 0, 1'b1, 3, n_mw, n_rw, rw_cyc, n_br, n_rs01, n_immj);
    check("beq_taken_pc_write", n_br, 1);
    run_instr("beq_not", 7'b1100011, 0, 1'b0, 3, n_mw, n_rw, rw_cyc, n_br, n_rs01, n_immj);
    check("beq_not_pc_write", n_br, 0);
    check("beq_reg_write", n_rw, 0);

    run_instr("jal", 7'b1101111, 0, 1'b0, 4, n_mw, n_rw, rw_cyc, n_br, n_rs01, n_immj);
    check("jal_pc_write", n_br, 1);
    check("jal_reg_write_cycle", rw_cyc, 4);
    check("jal_imm_src_j_cycles", n_immj, 4);

    // illegal opcode: dut1 traps, dut0 skips back to FETCH
    op = 7'b1111111;
    tick(1'b1, 1'b0, s1, s0);
    tick(1'b1, 1'b0, s1, s0);
    n_ill = 0; n_str = 0; n_ret0 = 0; n_ir0 = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0, s1, s0);
      if (s1[0]) n_ill++;
      if (s1[16] || s1[14] || s1[13] || s1[2] || s1[1]) n_str++;
      if (s0[1]) n_ret0++;
      if (s0[13]) n_ir0++;
    end
    $display("[TB] illegal op=%b trap_cycles=%0d skip_fetches=%0d", op, n_ill, n_ir0);
    check("trap_illegal_cycles", n_ill, 20);
    check("trap_no_strobes", n_str, 0);
    check("skip_no_retire", n_ret0, 0);
    check("skip_fetch_count", n_ir0, 10);

    rst_n = 1'b0;
    tick(1'b1, 1'b0, s1, s0);
    check("trap_cleared_by_reset", {31'd0, s1[0]}, 32'd0);
    rst_n = 1'b1;
    op = 7'b0110011;
    tick(1'b1, 1'b0, s1, s0);
    check("post_trap_fetch", {31'd0, s1[13]}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
